// File: rtl/uart_pkg.sv
// Shared UART constants used as defaults by the transmitter and its transmit buffer.
package uart_pkg;

    localparam int UART_DATA_WIDTH    = 8;
    localparam int UART_TX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Valid/ready byte handshake between the transmit buffer (master) and the UART transmitter (slave).
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] data_tx;
    logic                  valid_tx;
    logic                  ready_tx;

    modport master (
        output data_tx,
        output valid_tx,
        input  ready_tx
    );

    modport slave (
        input  data_tx,
        input  valid_tx,
        output ready_tx
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through transmit buffer: bus pushes without backpressure, the
// transmitter pops over valid/ready, and status flags feed the status registers.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = UART_TX_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_en,
    input  logic                   flush,
    input  logic                   clr_overflow,
    uart_tx_fifo_if.master         tx,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   idle
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Reject depths the wrap-bit pointer scheme cannot represent.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  push;
    logic                  pop;

    // Status is derived purely from registered pointers, so full/empty never see same-cycle traffic.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;
    assign idle  = empty && tx.ready_tx;

    assign tx.valid_tx = !empty;
    assign tx.data_tx  = mem[rd_ptr[AW-1:0]];

    // Flush overrides both sides; a push into a full buffer is dropped even if a pop frees a slot.
    assign push = wr_en && !full && !flush;
    assign pop  = !empty && tx.ready_tx && !flush;

    // Storage array is intentionally not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update; an async reset empties the buffer and drops valid_tx immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Sticky overflow: a dropped push wins over a same-cycle clear; flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full && !flush) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule
